// File: rtl/div_arbiter_if.sv
// rtl/div_arbiter_if.sv - request, divider and response channels of the shared-divider arbiter
interface div_arbiter_if #(
    parameter int N = 4,
    parameter int W = 32
);
    localparam int IW = $clog2(N);

    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_left;
    logic [N*W-1:0] req_right;

    logic           div_go;
    logic [W-1:0]   div_left;
    logic [W-1:0]   div_right;
    logic [W-1:0]   div_quotient;
    logic [W-1:0]   div_remainder;
    logic           div_done;

    logic           resp_valid;
    logic           resp_ready;
    logic [IW-1:0]  resp_id;
    logic [W-1:0]   resp_quotient;
    logic [W-1:0]   resp_remainder;
    logic           resp_err;

    modport master (
        output req_valid, req_left, req_right, div_quotient, div_remainder, div_done, resp_ready,
        input  req_ready, div_go, div_left, div_right, resp_valid, resp_id, resp_quotient,
               resp_remainder, resp_err
    );

    modport slave (
        input  req_valid, req_left, req_right, div_quotient, div_remainder, div_done, resp_ready,
        output req_ready, div_go, div_left, div_right, resp_valid, resp_id, resp_quotient,
               resp_remainder, resp_err
    );
endinterface

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin arbiter sharing one iterative divider among N requesters
module div_arbiter #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic          clk,
    input  logic          reset,
    div_arbiter_if.slave  bus,
    output logic          busy
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] winner;
    logic [IW-1:0] winner_inc;
    logic          found;
    logic [W-1:0]  win_left;
    logic [W-1:0]  win_right;

    logic [W-1:0]  left_q;
    logic [W-1:0]  right_q;
    logic [W-1:0]  quot_q;
    logic [W-1:0]  rem_q;
    logic [IW-1:0] id_q;
    logic          err_q;

    // First valid requester at or after ptr, wrapping modulo N.
    always_comb begin : search
        int idx;
        idx       = 0;
        found     = 1'b0;
        winner    = '0;
        win_left  = '0;
        win_right = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && bus.req_valid[idx]) begin
                found     = 1'b1;
                winner    = IW'(idx);
                win_left  = bus.req_left[idx*W +: W];
                win_right = bus.req_right[idx*W +: W];
            end
        end
        winner_inc = (winner == IW'(N-1)) ? '0 : winner + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = (win_right == '0) ? RESP : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (bus.div_done) state_nxt = RESP;
            RESP:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && found) begin
            bus.req_ready = N'(1) << winner;
        end
        bus.div_go     = (state == ISSUE);
        bus.resp_valid = (state == RESP);
        busy           = (state != IDLE);
    end

    // Divide-by-zero is answered here and skips the divider entirely.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr     <= '0;
            left_q  <= '0;
            right_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        left_q  <= win_left;
                        right_q <= win_right;
                        id_q    <= winner;
                        ptr     <= winner_inc;
                        if (win_right == '0) begin
                            quot_q <= '0;
                            rem_q  <= win_left;
                            err_q  <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (bus.div_done) begin
                        quot_q <= bus.div_quotient;
                        rem_q  <= bus.div_remainder;
                        err_q  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.div_left       = left_q;
    assign bus.div_right      = right_q;
    assign bus.resp_id        = id_q;
    assign bus.resp_quotient  = quot_q;
    assign bus.resp_remainder = rem_q;
    assign bus.resp_err       = err_q;
endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - self-checking bench for div_arbiter with a behavioural divider
module tb_div_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy;
    logic stray = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    div_arbiter_if #(.N(N), .W(W)) bus();

    div_arbiter #(.N(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Iterative divider: done W+1 cycles after go, or the next cycle for a zero dividend.
    int           dv_cnt;
    logic [W-1:0] dv_q;
    logic [W-1:0] dv_r;
    always @(posedge clk) begin
        if (!reset) begin
            dv_cnt <= 0;
        end else if (bus.div_go) begin
            dv_cnt <= (bus.div_left == '0) ? 1 : W + 1;
            dv_q   <= bus.div_left / bus.div_right;
            dv_r   <= bus.div_left % bus.div_right;
        end else if (dv_cnt > 0) begin
            dv_cnt <= dv_cnt - 1;
        end
    end
    assign bus.div_done      = (dv_cnt == 1) || stray;
    assign bus.div_quotient  = dv_q;
    assign bus.div_remainder = dv_r;

    function automatic void ref_div(input logic [W-1:0] l, input logic [W-1:0] r,
                                    output logic [W-1:0] q, output logic [W-1:0] rm,
                                    output logic e, output int lat);
        if (r == 0) begin
            q = '0; rm = l; e = 1'b1; lat = 1;
        end else begin
            q = l / r; rm = l % r; e = 1'b0; lat = (l == 0) ? 3 : W + 3;
        end
    endfunction

    task automatic drive_idle();
        bus.req_valid  = '0;
        bus.req_left   = '0;
        bus.req_right  = '0;
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({bus.resp_valid, bus.div_go, busy} !== 3'b000)
            $display("FAIL reset_ctrl: valid/go/busy=%b want 000", {bus.resp_valid, bus.div_go, busy}); else n_pass++;
        n_checks++; if (bus.req_ready !== '0) $display("FAIL reset_ready: got %b want 0", bus.req_ready); else n_pass++;
        n_checks++; if ({bus.resp_id, bus.resp_err} !== '0)
            $display("FAIL reset_id_err: got %0d/%b want 0/0", bus.resp_id, bus.resp_err); else n_pass++;
        n_checks++; if ({bus.div_left, bus.div_right, bus.resp_quotient, bus.resp_remainder} !== '0)
            $display("FAIL reset_regs: got %h %h %h %h want 0", bus.div_left, bus.div_right,
                     bus.resp_quotient, bus.resp_remainder); else n_pass++;
        reset = 1'b1;
    endtask

    task automatic run_op(input int i, input logic [W-1:0] l, input logic [W-1:0] r, input string name);
        logic [W-1:0] eq, er;
        logic         ee;
        int           elat, lat, gos, go_at;
        ref_div(l, r, eq, er, ee, elat);
        @(negedge clk);
        bus.req_left[i*W +: W]  = l;
        bus.req_right[i*W +: W] = r;
        bus.req_valid = N'(1) << i;
        #1;
        n_checks++; if (bus.req_ready !== N'(1) << i)
            $display("FAIL %s ready: got %b want %b", name, bus.req_ready, N'(1) << i); else n_pass++;
        lat = 0; gos = 0; go_at = -1;
        while (!bus.resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) bus.req_valid = '0;
            if (bus.div_go) begin
                gos++;
                if (go_at < 0) go_at = lat;
            end
        end
        n_checks++; if (lat !== elat) $display("FAIL %s latency: got %0d want %0d", name, lat, elat); else n_pass++;
        n_checks++; if (gos !== ((r != 0) ? 1 : 0))
            $display("FAIL %s go_count: got %0d want %0d", name, gos, (r != 0) ? 1 : 0); else n_pass++;
        if (r != 0) begin
            n_checks++; if (go_at !== 1) $display("FAIL %s go_cycle: got T+%0d want T+1", name, go_at); else n_pass++;
        end
        n_checks++; if (bus.resp_id !== IW'(i)) $display("FAIL %s id: got %0d want %0d", name, bus.resp_id, i); else n_pass++;
        n_checks++; if ({bus.resp_quotient, bus.resp_remainder, bus.resp_err} !== {eq, er, ee})
            $display("FAIL %s result: got q=%0d r=%0d e=%b want q=%0d r=%0d e=%b", name, bus.resp_quotient,
                     bus.resp_remainder, bus.resp_err, eq, er, ee); else n_pass++;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        n_checks++; if ({bus.resp_valid, busy} !== 2'b00)
            $display("FAIL %s release: valid/busy=%b want 00", name, {bus.resp_valid, busy}); else n_pass++;
    endtask

    task automatic test_fairness();
        logic [W-1:0] opl [N];
        logic [W-1:0] opr [N];
        logic [W-1:0] eq, er, cur_l, cur_r;
        logic         ee;
        int           elat, w, exp_ptr, cur_id, nresp, regen, cyc;
        bit           hs_prev;
        exp_ptr = 0; cur_id = 0; nresp = 0; regen = -1; cyc = 0; hs_prev = 0;
        cur_l = '0; cur_r = '0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            opl[i] = W'($urandom_range(0, 255));
            opr[i] = W'($urandom_range(0, 15));
            bus.req_left[i*W +: W]  = opl[i];
            bus.req_right[i*W +: W] = opr[i];
        end
        bus.req_valid  = '1;
        bus.resp_ready = 1'b1;
        while (nresp < 5 && cyc < 400) begin
            #1;
            if (hs_prev) begin
                n_checks++; if (bus.req_ready === '0)
                    $display("FAIL b2b_accept: got ready=%b want a grant", bus.req_ready); else n_pass++;
            end
            hs_prev = 0;
            if (bus.req_ready !== '0) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && bus.req_valid[(exp_ptr + k) % N]) w = (exp_ptr + k) % N;
                n_checks++; if (bus.req_ready !== N'(1) << w)
                    $display("FAIL fair_grant: got %b want %b", bus.req_ready, N'(1) << w); else n_pass++;
                cur_id = w; cur_l = opl[w]; cur_r = opr[w];
                exp_ptr = (w + 1) % N;
                regen = w;
            end
            if (bus.resp_valid) begin
                ref_div(cur_l, cur_r, eq, er, ee, elat);
                n_checks++; if (bus.resp_id !== IW'(cur_id))
                    $display("FAIL fair_id: got %0d want %0d", bus.resp_id, cur_id); else n_pass++;
                n_checks++; if ({bus.resp_quotient, bus.resp_remainder, bus.resp_err} !== {eq, er, ee})
                    $display("FAIL fair_result: got q=%0d r=%0d e=%b want q=%0d r=%0d e=%b", bus.resp_quotient,
                             bus.resp_remainder, bus.resp_err, eq, er, ee); else n_pass++;
                nresp++;
                hs_prev = 1;
            end
            @(negedge clk);
            cyc++;
            if (regen >= 0) begin
                opl[regen] = W'($urandom_range(0, 255));
                opr[regen] = W'($urandom_range(0, 15));
                bus.req_left[regen*W +: W]  = opl[regen];
                bus.req_right[regen*W +: W] = opr[regen];
                regen = -1;
            end
        end
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        n_checks++; if (nresp !== 5) $display("FAIL fair_count: got %0d responses want 5", nresp); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] eq, er;
        logic         ee;
        int           elat, lat;
        bit           ok;
        ref_div(8'd200, 8'd9, eq, er, ee, elat);
        @(negedge clk);
        bus.req_left[0 +: W]  = 8'd200;
        bus.req_right[0 +: W] = 8'd9;
        bus.req_valid = 4'b0001;
        lat = 0;
        while (!bus.resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                for (int i = 1; i < N; i++) begin
                    bus.req_left[i*W +: W]  = W'($urandom_range(0, 255));
                    bus.req_right[i*W +: W] = W'($urandom_range(1, 15));
                end
                bus.req_valid = '1;
            end
        end
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            ok = bus.resp_valid === 1'b1 && bus.resp_id === IW'(0) && bus.resp_quotient === eq &&
                 bus.resp_remainder === er && bus.resp_err === ee && bus.req_ready === '0 && bus.div_go === 1'b0;
            n_checks++; if (!ok)
                $display("FAIL bp_hold%0d: got v=%b id=%0d q=%0d r=%0d e=%b rdy=%b go=%b want v=1 id=0 q=%0d r=%0d e=%b rdy=0 go=0",
                         k, bus.resp_valid, bus.resp_id, bus.resp_quotient, bus.resp_remainder, bus.resp_err,
                         bus.req_ready, bus.div_go, eq, er, ee); else n_pass++;
        end
        bus.resp_ready = 1'b1;
        bus.req_valid  = '0;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        n_checks++; if ({bus.resp_valid, busy} !== 2'b00)
            $display("FAIL bp_release: valid/busy=%b want 00", {bus.resp_valid, busy}); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        int lat;
        @(negedge clk);
        bus.req_left[0 +: W]  = 8'd77;
        bus.req_right[0 +: W] = 8'd3;
        bus.req_valid = 4'b0001;
        @(negedge clk);
        bus.req_valid = '0;
        n_checks++; if (bus.div_go !== 1'b1) $display("FAIL rst_go: got %b want 1", bus.div_go); else n_pass++;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n_checks++; if ({bus.resp_valid, bus.div_go, busy, bus.req_ready} !== '0)
            $display("FAIL rst_ctrl: got %b want 0", {bus.resp_valid, bus.div_go, busy, bus.req_ready}); else n_pass++;
        n_checks++; if ({bus.resp_id, bus.resp_err, bus.div_left, bus.div_right, bus.resp_quotient, bus.resp_remainder} !== '0)
            $display("FAIL rst_regs: got id=%0d e=%b l=%0d r=%0d q=%0d rm=%0d want 0", bus.resp_id, bus.resp_err,
                     bus.div_left, bus.div_right, bus.resp_quotient, bus.resp_remainder); else n_pass++;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        n_checks++; if ({bus.resp_valid, busy} !== 2'b00)
            $display("FAIL rst_stray: valid/busy=%b want 00", {bus.resp_valid, busy}); else n_pass++;
        // Requesters 0 and 1 together: a cleared pointer must pick 0.
        bus.req_left[0 +: W]  = 8'd90;
        bus.req_right[0 +: W] = 8'd4;
        bus.req_left[W +: W]  = 8'd11;
        bus.req_right[W +: W] = 8'd2;
        bus.req_valid = 4'b0011;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) $display("FAIL rst_ptr: got %b want 0001", bus.req_ready); else n_pass++;
        lat = 0;
        while (!bus.resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) bus.req_valid = '0;
        end
        n_checks++; if ({bus.resp_id, bus.resp_quotient, bus.resp_remainder, bus.resp_err} !== {2'd0, 8'd22, 8'd2, 1'b0})
            $display("FAIL rst_follow: got id=%0d q=%0d r=%0d e=%b want id=0 q=22 r=2 e=0", bus.resp_id,
                     bus.resp_quotient, bus.resp_remainder, bus.resp_err); else n_pass++;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fairness();
        run_op(2, 8'd100, 8'd7, "single");
        run_op(1, 8'd55, 8'd0, "div_zero");
        run_op(3, 8'd0, 8'd5, "zero_dividend");
        for (int k = 0; k < 4; k++)
            run_op(int'($urandom_range(0, N-1)), W'($urandom_range(0, 255)), W'($urandom_range(0, 20)), "random");
        test_backpressure();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter that shares one iterative divider (go/done, W-bit quotient and remainder) among N requesters. Each requester issues a division over a valid/ready request channel. The block holds the operands, sequences the divider's `go`/`done` handshake, and returns results on one shared response channel tagged with the requester index. Divide-by-zero is resolved locally and never reaches the divider.

## Interface
- `N`, 4: number of requesters; N ≥ 2.
- `W`, 32: operand and result width; must match the divider's `W`.
- `IW`, `$clog2(N)`: requester index width (derived; do not override).

- `clk`  in  1  clock; all logic on posedge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `req_valid`  in  N  per-requester request valid.
- `req_ready`  out  N  per-requester accept; one-hot or zero.
- `req_left`  in  N*W  dividends; requester i at `[i*W +: W]`.
- `req_right`  in  N*W  divisors; same packing.
- `div_go`  out  1  single-cycle start pulse to the divider.
- `div_left`, `div_right`  out  W each  operands to the divider; held stable from the `div_go` cycle until `div_done`.
- `div_quotient`, `div_remainder`  in  W each  divider results; valid in the `div_done` cycle.
- `div_done`  in  1  one-cycle completion pulse from the divider.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  response accept.
- `resp_id`  out  IW  index of the requester that issued the op.
- `resp_quotient`, `resp_remainder`  out  W each  results.
- `resp_err`  out  1  1 = divide by zero.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - The winner is the first i with `req_valid[i]`, searching from `ptr`, then `ptr+1`, … (mod N).
  - `req_ready[winner]` is asserted combinationally in the same cycle, and the request is accepted that cycle. `req_ready` depends on `req_valid`.
  - On accept, latch left, right and id, and set `ptr <= winner+1` (mod N).
  - If latched right == 0: go to RESP with quotient=0, remainder=left, err=1.
  - Otherwise go to ISSUE.
  - If no `req_valid` is high: stay in IDLE and leave `ptr` unchanged.
- **ISSUE**: `div_go`=1 for exactly this cycle, then go to WAIT.
- **WAIT**
  - `div_go`=0.
  - On `div_done`: capture `div_quotient` and `div_remainder`, set err=0, go to RESP.
  - No timeout; the block waits indefinitely.
- **RESP**
  - `resp_valid`=1; id, quotient, remainder and err are held stable.
  - On `resp_ready` go to IDLE. No new request is accepted in that same cycle.
- `req_ready` is 0 in every state except IDLE.
- `div_done` seen outside WAIT is ignored.
- `div_left`/`div_right` always drive the latched operand registers.
- Only one operation is in flight; there is no queueing.

## Timing
- Reset (`reset`=0 at a posedge) forces:
  - state IDLE, `ptr`=0;
  - operand and result registers 0, `resp_err`=0;
  - outputs `resp_valid`, `div_go`, `req_ready`, `busy`, `resp_id` all 0.
- Reset mid-operation (ISSUE, WAIT or RESP) aborts the op with no response. The divider shares `reset` at the top level.
- Let T be the accept cycle. Then:
  - `div_go` in T+1;
  - earliest `div_done` in T+2;
  - `resp_valid` rises the cycle after `div_done`.
  - Team iterative divider: `div_done` = T+W+2, `resp_valid` = T+W+3.
  - Zero dividend: `div_done` = T+2, `resp_valid` = T+3.
- Divide-by-zero: `resp_valid` at T+1; `div_go` never fires.
- Back-to-back throughput: with `resp_ready` held high, next accept is at the cycle after the response handshake.
- Simultaneous requests: exactly one is granted per accept, and `ptr` guarantees no requester waits more than N-1 grants.
- `req_valid` deasserted by a requester before its grant: no state change for that requester.

## Test plan
- **Single op:** with N=4, W=8, requester 2 sends 100/7 while others idle. Require `req_ready`=0b0100 in T, `div_go` at T+1, `resp_valid` at T+11, id=2, q=14, r=2, err=0.
- **Divide by zero:** requester 1 sends 55/0. Require `resp_valid` at T+1, q=0, r=55, err=1, `div_go` never asserted.
- **Fairness:** all four `req_valid` held high with distinct ops and `resp_ready`=1. Require grant order 0,1,2,3,0; each response carries the matching id and results.
- **Backpressure:** `resp_ready`=0 for 5 cycles after `resp_valid` rises. Require outputs stable, `req_ready` stays 0, and no second `div_go`.
- **Reset mid-WAIT:** `reset`=0 for one cycle, 3 cycles after `div_go`. Require all outputs 0 next cycle, `ptr`=0, and the later stray `div_done` ignored. A following request from requester 0 completes normally.
- **Zero dividend:** requester 3 sends 0/5. Require `resp_valid` at T+3, q=0, r=0, err=0.
